adc_sar_control: RTL and testbench

Successive-approximation control logic for the SAR ADC. It runs directly downstream of the clock generator, on its self-timed digital clock. Each conversion runs a programmable sample phase, then resolves RESOLUTION bits MSB-first from the comparator decision and drives the capacitive-DAC switch words. The final code is held and signalled to the digital core, which then drops the clock generator enable and halts the loop.

---
 rtl/adc_sar_pkg.sv | 20 ++
 rtl/adc_sar_control.sv | 130 +++++++++++++
 tb/tb_adc_sar_control.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sar_pkg
//  Brief    : Shared state encoding and sizing constants for the SAR control.
//  Revision : 1.0 - initial release
// ============================================================================
package adc_sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_t;

    localparam int c_default_resolution = 12;
    localparam int c_bit_idx_w          = $clog2(c_default_resolution);

endpackage
`default_nettype wire

// File: rtl/adc_sar_control.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sar_control
//  Brief    : SAR ADC sequencer: sample phase, MSB-first bit trials, held code.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_sar_control
    import adc_sar_pkg::*;
#(
    parameter int RESOLUTION   = c_default_resolution,
    parameter int SAMPLE_CNT_W = 4
) (
    input  logic                    clk_dig_in,
    input  logic                    rst_in,
    input  logic                    en_in,
    input  logic                    start_in,
    input  logic [SAMPLE_CNT_W-1:0] sample_cycles_in,
    input  logic                    comparator_in,
    output logic                    sample_p_out,
    output logic                    sample_n_out,
    output logic                    nsample_p_out,
    output logic                    nsample_n_out,
    output logic [RESOLUTION-1:0]   dac_p_out,
    output logic [RESOLUTION-1:0]   dac_n_out,
    output logic [RESOLUTION-1:0]   result_out,
    output logic                    conv_finish_out,
    output logic                    busy_out
);

    localparam int                    c_idx_w   = $clog2(RESOLUTION);
    localparam logic [RESOLUTION-1:0] c_msb     = {1'b1, {(RESOLUTION-1){1'b0}}};
    localparam logic [c_idx_w-1:0]    c_idx_top = c_idx_w'(RESOLUTION - 1);

    sar_state_t              r_state, w_state_nxt;
    logic [SAMPLE_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_load;
    logic [c_idx_w-1:0]      r_idx, w_idx_nxt;
    logic [RESOLUTION-1:0]   r_sar, w_sar_nxt;
    logic [RESOLUTION-1:0]   r_result, w_result_nxt;
    logic                    r_sample, r_finish, r_busy;

    // A zero-length request still samples for one edge.
    assign w_cnt_load = (sample_cycles_in == '0) ? '0 : sample_cycles_in - SAMPLE_CNT_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_sar_nxt    = r_sar;
        w_result_nxt = r_result;
        if (!en_in) begin
            w_state_nxt = ST_IDLE;
            w_sar_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_sar_nxt = '0;
                    if (start_in) begin
                        w_state_nxt = ST_SAMPLE;
                        w_cnt_nxt   = w_cnt_load;
                    end
                end
                ST_SAMPLE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_CONVERT;
                        w_sar_nxt   = c_msb;
                        w_idx_nxt   = c_idx_top;
                    end else begin
                        w_cnt_nxt = r_cnt - SAMPLE_CNT_W'(1);
                    end
                end
                ST_CONVERT: begin
                    // Comparator high means the trial is not above the input: keep the bit.
                    w_sar_nxt[r_idx] = comparator_in;
                    if (r_idx != '0) begin
                        w_sar_nxt[r_idx - c_idx_w'(1)] = 1'b1;
                        w_idx_nxt                      = r_idx - c_idx_w'(1);
                    end else begin
                        w_result_nxt = w_sar_nxt;
                        w_state_nxt  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start_in) begin
                        w_state_nxt = ST_SAMPLE;
                        w_cnt_nxt   = w_cnt_load;
                        w_sar_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sar_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_dig_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_sar    <= '0;
            r_result <= '0;
            r_sample <= 1'b0;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_sar    <= w_sar_nxt;
            r_result <= w_result_nxt;
            r_sample <= (w_state_nxt == ST_SAMPLE);
            r_finish <= (w_state_nxt == ST_DONE);
            r_busy   <= (w_state_nxt == ST_SAMPLE) || (w_state_nxt == ST_CONVERT);
        end
    end

    assign sample_p_out    = r_sample;
    assign sample_n_out    = r_sample;
    assign nsample_p_out   = ~r_sample;
    assign nsample_n_out   = ~r_sample;
    assign dac_p_out       = r_sar;
    assign dac_n_out       = ~r_sar;
    assign result_out      = r_result;
    assign conv_finish_out = r_finish;
    assign busy_out        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_adc_sar_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_sar_control
//  Brief    : Randomized scoreboard bench for the SAR control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sar_control;

    localparam int R  = 12;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst, en, start, comp;
    logic [SW-1:0] scyc;
    logic          sp, sn, nsp, nsn, fin, busy;
    logic [R-1:0]  dac_p, dac_n, result;

    int            cmp_mode;
    logic [R-1:0]  target;
    logic [R-1:0]  last_exp;
    int            edge_no  = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    typedef struct {
        int           accept;
        int           n;
        logic [R-1:0] exp;
    } conv_t;
    conv_t sb[$];

    adc_sar_control #(.RESOLUTION(R), .SAMPLE_CNT_W(SW)) dut (
        .clk_dig_in      (clk),
        .rst_in          (rst),
        .en_in           (en),
        .start_in        (start),
        .sample_cycles_in(scyc),
        .comparator_in   (comp),
        .sample_p_out    (sp),
        .sample_n_out    (sn),
        .nsample_p_out   (nsp),
        .nsample_n_out   (nsn),
        .dac_p_out       (dac_p),
        .dac_n_out       (dac_n),
        .result_out      (result),
        .conv_finish_out (fin),
        .busy_out        (busy)
    );

    always #5 clk = ~clk;

    // Comparator: fixed decision, or an ideal comparator against an analog target.
    assign comp = (cmp_mode == 2) ? (dac_p <= target) : (cmp_mode == 1);

    initial forever begin
        @(posedge clk);
        edge_no++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Monitor: invariants every cycle, per-conversion windows and completion checks.
    int           m_d, m_b;
    logic [31:0]  m_trial;
    logic         prev_fin = 1'b0;
    conv_t        m_e;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("dac_n_complement", dac_n, R'(~dac_p));
            chk("nsample_p_complement", nsp, 1'(~sp));
            chk("nsample_n_complement", nsn, 1'(~sn));
            chk("sample_pn_equal", sn, sp);
            if (sb.size() > 0) begin
                m_d = edge_no - sb[0].accept;
                if (m_d >= 0 && m_d < sb[0].n) begin
                    chk("sample_high", sp, 1);
                end else if (m_d >= sb[0].n && m_d < sb[0].n + R) begin
                    chk("sample_low_convert", sp, 0);
                    chk("busy_convert", busy, 1);
                    // Bits above the trial bit are already final; trial bit set, rest clear.
                    m_b     = R - 1 - (m_d - sb[0].n);
                    m_trial = (32'(sb[0].exp) & ~((32'd1 << (m_b + 1)) - 32'd1)) | (32'd1 << m_b);
                    chk("dac_trace", dac_p, m_trial);
                end
            end
            if (fin && !prev_fin) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_finish: conv_finish_out=1, expected no completion (edge %0d)", edge_no);
                end else begin
                    m_e = sb.pop_front();
                    chk("result", result, m_e.exp);
                    chk("latency", edge_no - m_e.accept, m_e.n + R);
                    chk("dac_final", dac_p, m_e.exp);
                end
            end
        end
        prev_fin = fin;
    end

    task automatic issue(input int mode, input logic [SW-1:0] sc, input logic [R-1:0] tgt,
                         input bit push, output int accept);
        conv_t e;
        cmp_mode = mode;
        target   = tgt;
        scyc     = sc;
        start    = 1'b1;
        e.accept = edge_no + 1;
        e.n      = (sc == '0) ? 1 : int'(sc);
        e.exp    = (mode == 2) ? tgt : ((mode == 1) ? {R{1'b1}} : {R{1'b0}});
        accept   = e.accept;
        if (push) begin
            sb.push_back(e);
            last_exp = e.exp;
        end
    endtask

    task automatic wait_fin(input string name);
        int t = 0;
        while (!fin && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: conv_finish_out=%0b, expected 1 within 200 edges", name, fin);
        end
    endtask

    task automatic run_conv(input int mode, input logic [SW-1:0] sc, input logic [R-1:0] tgt);
        int a;
        issue(mode, sc, tgt, 1'b1, a);
        @(negedge clk);
        start = 1'b0;
        scyc  = SW'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_fin("conv");
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        int a, lowcnt;
        rst = 1'b1; en = 1'b0; start = 1'b0; scyc = '0;
        cmp_mode = 0; target = '0; last_exp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_sample_p", sp, 0);
        chk("rst_sample_n", sn, 0);
        chk("rst_nsample_p", nsp, 1);
        chk("rst_nsample_n", nsn, 1);
        chk("rst_dac_p", dac_p, 0);
        chk("rst_dac_n", dac_n, 12'hFFF);
        chk("rst_result", result, 0);
        chk("rst_finish", fin, 0);
        chk("rst_busy", busy, 0);

        en = 1'b1;
        @(negedge clk);
        run_conv(1, 4'd3, '0);
        run_conv(0, 4'd3, '0);
        run_conv(2, 4'd3, 12'hA5C);
        run_conv(2, 4'd0, R'($urandom));
        for (int i = 0; i < 10; i++) begin
            run_conv(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : 2,
                     SW'($urandom), R'($urandom));
        end

        // Enable dropped mid-conversion: back to idle, previous code retained.
        issue(2, 4'd3, R'($urandom), 1'b0, a);
        @(negedge clk);
        start = 1'b0;
        while (edge_no < a + 5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_en_busy", busy, 0);
        chk("abort_en_sample", sp, 0);
        chk("abort_en_dac_p", dac_p, 0);
        chk("abort_en_finish", fin, 0);
        chk("abort_en_result_kept", result, last_exp);
        en = 1'b1;
        @(negedge clk);
        run_conv(2, 4'd2, R'($urandom));

        // Reset pulsed mid-conversion: outputs clear without waiting for a clock edge.
        issue(2, 4'd3, R'($urandom), 1'b0, a);
        @(negedge clk);
        start = 1'b0;
        while (edge_no < a + 6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_rst_sample_p", sp, 0);
        chk("abort_rst_nsample_n", nsn, 1);
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_finish", fin, 0);
        chk("abort_rst_dac_p", dac_p, 0);
        chk("abort_rst_dac_n", dac_n, 12'hFFF);
        chk("abort_rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_conv(2, 4'd5, R'($urandom));

        // Start held through completion: the next conversion follows directly.
        issue(2, 4'd3, R'($urandom), 1'b1, a);
        @(negedge clk);
        wait_fin("b2b_first");
        issue(2, 4'd3, R'($urandom), 1'b1, a);
        lowcnt = 0;
        do begin
            @(negedge clk);
            if (!fin) lowcnt++;
        end while (!fin && lowcnt < 100);
        start = 1'b0;
        chk("b2b_finish_low_edges", lowcnt, 15);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
